instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
//  Parametrised prefetching front end: generates sequential PCs, issues pipelined
//  requests to instruction memory, buffers in-order responses with their PCs in a
//  DEPTH-entry FIFO, and hands {pc, instr} to decode over a valid/ready handshake.
//  A PC redirect from execute flushes the queue and drops stale in-flight responses.
// PARAMETERS
//  PC_W      32  PC / instruction-address width
//  INSTR_W   32  instruction width
//  DEPTH     4   FIFO entries; also the max (buffered + outstanding) credit, >=2
//  PC_STEP   1   sequential PC increment
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk            in   1        clock, all logic on posedge
//  rst_n_i        in   1        synchronous active-low reset
//  write_pc_i     in   1        redirect strobe
//  pc_i           in   PC_W     redirect target
//  imem_req_o     out  1        request valid
//  imem_addr_o    out  PC_W     request address (= fetch PC)
//  imem_gnt_i     in   1        request accepted this cycle
//  imem_rvalid_i  in   1        response valid; responses arrive in request order
//  imem_rdata_i   in   INSTR_W  response data
//  out_valid_o    out  1        head entry valid
//  out_ready_i    in   1        decode accepts head
//  out_pc_o       out  PC_W     head PC
//  out_instr_o    out  INSTR_W  head instruction
// BEHAVIOUR
//  - Reset (rst_n_i=0 at posedge): fetch PC=RESET_PC, FIFO empty, outstanding=0,
//    discard=0; imem_req_o=0, out_valid_o=0, out_pc_o=0, out_instr_o=0 next cycle.
//    Memory shares this reset, so no response crosses a reset.
//  - Credit: imem_req_o=1 iff occupancy+outstanding < DEPTH and write_pc_i=0.
//    Request fires on imem_req_o&imem_gnt_i: outstanding++, fetch PC+=PC_STEP (mod 2^PC_W).
//  - Address-tag FIFO (DEPTH entries) records PC of each fired request; popped on response.
//  - Response (imem_rvalid_i, discard=0): push {tag PC, rdata} into FIFO, outstanding--.
//    Response with discard>0: dropped, discard--, outstanding--.
//  - Output: out_* show FIFO head, registered; pop on out_valid_o&out_ready_i.
//    Push and pop in the same cycle legal at any occupancy; credit rule ensures no overflow.
//  - Latency: response in cycle N -> out_valid_o in N+1 (empty FIFO); no combinational
//    path from imem_* or out_ready_i to out_*.
//  - Redirect (write_pc_i=1 in cycle N): FIFO and tag FIFO cleared, fetch PC=pc_i;
//    discard = outstanding after cycle-N request/response updates (fired request and
//    unconsumed response in N both count); out_valid_o=0 from N+1; first request to pc_i
//    driven in N+1. Redirect overrides any same-cycle pop (pop is lost, not an error).
//  - Redirect during nonzero discard accumulates; responses never reach FIFO until discard=0.
//  - Counters sized $clog2(DEPTH+1); pointers wrap modulo DEPTH.
// CONFIGURATION
//  INSTR_FETCH_PERF_EN defined: adds outputs perf_fetched_o [31:0] (pops) and
//    perf_stall_o [31:0] (cycles out_valid_o=0, excluding reset), reset to 0, saturate at
//    2^32-1; perf_flush_o [15:0] counts redirects, saturating.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after grant, ready=1 -> out_pc 0,1,2,3... one per cycle.
//  2 ready=0, DEPTH=4 -> exactly 4 requests (PC 0..3), imem_req_o=0 until a pop frees credit.
//  3 Two requests outstanding, write_pc_i=1 pc_i=0x40 -> next two responses dropped,
//    first out_pc_o=0x40, FIFO empty in cycle after redirect.
//  4 Redirect same cycle as rvalid and out handshake -> both discarded, out_valid_o=0 next.
//  5 PC_W=8, pc_i=0xFE, PC_STEP=1 -> out_pc 0xFE,0xFF,0x00.
//  6 rst_n_i low with full FIFO -> out_valid_o=0, imem_req_o=0, then fetch at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Prefetching instruction front end: sequential PC generation, pipelined imem requests,
// in-order response FIFO with redirect flush. Define INSTR_FETCH_PERF_EN for perf counters.
module instruction_fetch_queue #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               write_pc_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [INSTR_W-1:0] out_instr_o
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_stall_o,
    output logic [15:0]        perf_flush_o
`endif
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W:0]   CREDIT   = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic               run_q;
    logic [PC_W-1:0]    fetch_pc_q;
    logic [CNT_W-1:0]   occ_q;
    logic [CNT_W-1:0]   outst_q;
    logic [CNT_W-1:0]   discard_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   tag_rptr_q;
    logic [PTR_W-1:0]   tag_wptr_q;
    logic [PC_W-1:0]    tag_mem   [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic               head_vld_p1;
    logic [PC_W-1:0]    head_pc_p1;
    logic [INSTR_W-1:0] head_instr_p1;

    logic               fire;
    logic               tag_empty;
    logic               resp_keep;
    logic               tag_push;
    logic               tag_pop;
    logic               pop;
    logic [PC_W-1:0]    resp_pc;
    logic [CNT_W:0]     in_flight;
    logic [CNT_W-1:0]   outst_nxt;
    logic [CNT_W-1:0]   occ_left;
    logic [CNT_W-1:0]   occ_nxt;
    logic [PTR_W-1:0]   rptr_nxt;

    // Stage 0: credit, request/response bookkeeping and FIFO next-state
    always_comb begin
        in_flight  = {1'b0, occ_q} + {1'b0, outst_q};
        imem_req_o = run_q & ~write_pc_i & (in_flight < CREDIT);
        fire       = imem_req_o & imem_gnt_i;
        // Non-discarded outstanding requests are exactly the live tag entries.
        tag_empty  = (outst_q == discard_q);
        resp_keep  = imem_rvalid_i & (discard_q == '0) & ~write_pc_i;
        resp_pc    = tag_empty ? fetch_pc_q : tag_mem[tag_rptr_q];
        tag_push   = fire & ~(resp_keep & tag_empty);
        tag_pop    = resp_keep & ~tag_empty;
        pop        = head_vld_p1 & out_ready_i & ~write_pc_i;
        outst_nxt  = outst_q + CNT_W'(fire) - CNT_W'(imem_rvalid_i);
        occ_left   = occ_q - CNT_W'(pop);
        occ_nxt    = occ_left + CNT_W'(resp_keep);
        rptr_nxt   = pop ? ptr_inc(rptr_q) : rptr_q;
    end

    assign imem_addr_o = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (resp_keep) begin
            pc_mem[wptr_q]    <= resp_pc;
            instr_mem[wptr_q] <= imem_rdata_i;
        end
        if (tag_push) begin
            tag_mem[tag_wptr_q] <= fetch_pc_q;
        end
    end

    // Stage 1: registered control state and head-of-queue output register
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            occ_q         <= '0;
            outst_q       <= '0;
            discard_q     <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            tag_rptr_q    <= '0;
            tag_wptr_q    <= '0;
            head_vld_p1   <= 1'b0;
            head_pc_p1    <= '0;
            head_instr_p1 <= '0;
        end else begin
            run_q   <= 1'b1;
            outst_q <= outst_nxt;
            if (write_pc_i) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc_q  <= pc_i;
                discard_q   <= outst_nxt;
                occ_q       <= '0;
                rptr_q      <= '0;
                wptr_q      <= '0;
                tag_rptr_q  <= '0;
                tag_wptr_q  <= '0;
                head_vld_p1 <= 1'b0;
            end else begin
                if (fire) begin
                    fetch_pc_q <= fetch_pc_q + PC_W'(PC_STEP);
                end
                if (imem_rvalid_i && (discard_q != '0)) begin
                    discard_q <= discard_q - CNT_W'(1);
                end
                occ_q  <= occ_nxt;
                rptr_q <= rptr_nxt;
                if (resp_keep) begin
                    wptr_q <= ptr_inc(wptr_q);
                end
                if (tag_push) begin
                    tag_wptr_q <= ptr_inc(tag_wptr_q);
                end
                if (tag_pop) begin
                    tag_rptr_q <= ptr_inc(tag_rptr_q);
                end
                head_vld_p1 <= (occ_nxt != '0);
                if (occ_left != '0) begin
                    head_pc_p1    <= pc_mem[rptr_nxt];
                    head_instr_p1 <= instr_mem[rptr_nxt];
                end else if (resp_keep) begin
                    head_pc_p1    <= resp_pc;
                    head_instr_p1 <= imem_rdata_i;
                end
            end
        end
    end

    assign out_valid_o = head_vld_p1;
    assign out_pc_o    = head_pc_p1;
    assign out_instr_o = head_instr_p1;

`ifdef INSTR_FETCH_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    logic [31:0] fetched_q;
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            fetched_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (pop) begin
                fetched_q <= sat_inc32(fetched_q);
            end
            if (!head_vld_p1) begin
                stall_q <= sat_inc32(stall_q);
            end
            if (write_pc_i) begin
                flush_q <= sat_inc16(flush_q);
            end
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_stall_o   = stall_q;
    assign perf_flush_o   = flush_q;
`endif

endmodule
